// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Streams a program into instruction memory one byte at a time, packs the bytes
// little-endian into 32-bit words, writes each word, and releases the CPU with
// a single start pulse once the final word is stored.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   byte_valid_i   source presents a program byte
//   byte_data_i    program byte
//   last_i         marks the final program byte (qualified by the handshake)
//   byte_ready_o   loader accepts a byte this cycle
//   wr_en_o        instruction-memory write strobe (one-cycle pulse)
//   wr_addr_o      byte address of the word being written
//   wr_data_o      word being written
//   start_o        one-cycle pulse releasing the CPU after a good load
//   busy_o         load in progress
//   done_o         load completed (sticky until reset)
//   err_o          memory overflow (sticky until reset)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    input  logic        last_i,
    output logic        byte_ready_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        start_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    // One extra count value so the index can reach DEPTH_WORDS without wrapping.
    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FIN, DONE, ERR} state_t;

    state_t            state_q;
    logic [31:0]       buf_q;
    logic [1:0]        cnt_q;
    logic [IDX_W-1:0]  widx_q;
    logic              wr_en_q;
    logic [31:0]       wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              start_q;

    logic              accept_state;
    logic              hs;
    logic              mem_full;
    logic [31:0]       word_d;

    assign accept_state = (state_q == IDLE) || (state_q == LOAD);
    // Reset is folded in so ready drops the instant rst_i rises.
    assign byte_ready_o = accept_state & ~rst_i;
    assign hs           = byte_valid_i & byte_ready_o;
    assign mem_full     = (widx_q == IDX_W'(DEPTH_WORDS));

    // Current buffer with the incoming byte dropped into its lane. The buffer is
    // cleared after every word, so unfilled upper lanes of a final partial word
    // are already zero.
    always_comb begin
        word_d = buf_q;
        word_d[{cnt_q, 3'b000} +: 8] = byte_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            widx_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    if (hs) begin
                        if (mem_full) begin
                            // Overflow: byte is dropped, nothing is written.
                            state_q <= ERR;
                        end else if (cnt_q == 2'd3 || last_i) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= BASE_ADDR + (32'(widx_q) << 2);
                            wr_data_q <= word_d;
                            widx_q    <= widx_q + IDX_W'(1);
                            buf_q     <= '0;
                            cnt_q     <= '0;
                            state_q   <= last_i ? FIN : LOAD;
                        end else begin
                            buf_q   <= word_d;
                            cnt_q   <= cnt_q + 2'd1;
                            state_q <= LOAD;
                        end
                    end
                end
                FIN: begin
                    // First FIN cycle carries the final write; start follows it
                    // in the second FIN cycle, then the loader parks in DONE.
                    if (wr_en_q) begin
                        start_q <= 1'b1;
                    end else if (start_q) begin
                        start_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= DONE;
                ERR:  state_q <= ERR;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign start_o   = start_q;
    assign busy_o    = (state_q == LOAD) || (state_q == FIN);
    assign done_o    = (state_q == DONE);
    assign err_o     = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        last = 1'b0;
    logic        sel = 1'b0;   // 0: default-depth loader, 1: two-word loader

    logic        ready_a, wr_en_a, start_a, busy_a, done_a, err_a;
    logic [31:0] wr_addr_a, wr_data_a;
    logic        ready_b, wr_en_b, start_b, busy_b, done_b, err_b;
    logic [31:0] wr_addr_b, wr_data_b;

    wire m_ready = sel ? ready_b : ready_a;
    wire m_wr_en = sel ? wr_en_b : wr_en_a;
    wire m_start = sel ? start_b : start_a;
    wire m_busy  = sel ? busy_b  : busy_a;
    wire m_done  = sel ? done_b  : done_a;
    wire m_err   = sel ? err_b   : err_a;
    wire [31:0] m_addr = sel ? wr_addr_b : wr_addr_a;
    wire [31:0] m_data = sel ? wr_data_b : wr_data_a;

    imem_loader u_dut (
        .clk_i(clk), .rst_i(rst),
        .byte_valid_i(byte_valid & ~sel), .byte_data_i(byte_data), .last_i(last),
        .byte_ready_o(ready_a), .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a),
        .wr_data_o(wr_data_a), .start_o(start_a), .busy_o(busy_a),
        .done_o(done_a), .err_o(err_a)
    );

    imem_loader #(.DEPTH_WORDS(2)) u_dut_small (
        .clk_i(clk), .rst_i(rst),
        .byte_valid_i(byte_valid & sel), .byte_data_i(byte_data), .last_i(last),
        .byte_ready_o(ready_b), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b),
        .wr_data_o(wr_data_b), .start_o(start_b), .busy_o(busy_b),
        .done_o(done_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/start log, sampled on the falling edge.
    logic [31:0] w_addr[$];
    logic [31:0] w_data[$];
    int          w_cyc[$];
    int          s_cyc[$];
    int          collide = 0;
    always @(negedge clk) begin
        if (m_wr_en) begin
            w_addr.push_back(m_addr);
            w_data.push_back(m_data);
            w_cyc.push_back(cyc);
        end
        if (m_start) s_cyc.push_back(cyc);
        if (m_wr_en && m_start) collide++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    logic [7:0] stim[0:63];
    logic [31:0] ref_data[$];
    int          ref_cyc[$];

    task automatic clear_log();
        w_addr.delete(); w_data.delete(); w_cyc.delete(); s_cyc.delete();
        collide = 0;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop at once.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        check({tag, "_rst_outs"},
              {26'd0, m_ready, m_wr_en, m_start, m_busy, m_done, m_err}, 32'd0);
        check({tag, "_rst_addrdata"}, m_addr | m_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int waited = 0;
        byte_valid = 1'b1; byte_data = b; last = l;
        forever begin
            @(negedge clk);
            if (m_ready) begin
                @(posedge clk); #1;
                break;
            end
            waited++;
            if (waited > 50) begin
                check("hs_timeout", 32'd1, 32'd0);
                break;
            end
        end
        byte_valid = 1'b0; last = 1'b0;
    endtask

    task automatic run_stream(input int n, input logic with_last, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    byte_data = 8'($urandom_range(0, 255));
                    last = 1'b1;          // ignored without valid
                    @(posedge clk); #1;
                    last = 1'b0;
                end
            end
            send_byte(stim[i], with_last && (i == n - 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] exp_w;
        int wr_snap, st_snap, rdy_seen;

        // ---- reset state ----
        #2;
        check("init_outs", {26'd0, m_ready, m_wr_en, m_start, m_busy, m_done, m_err}, 32'd0);
        @(posedge clk); #1;
        pulse_reset("t0");
        @(negedge clk);
        check("idle_ready", {31'd0, m_ready}, 32'd1);
        check("idle_busy", {31'd0, m_busy}, 32'd0);
        @(posedge clk); #1;

        // ---- two full words back-to-back ----
        stim[0]=8'h13; stim[1]=8'h00; stim[2]=8'h00; stim[3]=8'h00;
        stim[4]=8'h93; stim[5]=8'h00; stim[6]=8'h10; stim[7]=8'h00;
        run_stream(8, 1'b1, 1'b0);
        idle_cycles(5);
        check("t1_nwr", w_addr.size(), 2);
        if (w_addr.size() == 2) begin
            check("t1_a0", w_addr[0], 32'h0);
            check("t1_d0", w_data[0], 32'h00000013);
            check("t1_a1", w_addr[1], 32'h4);
            check("t1_d1", w_data[1], 32'h00100093);
            check("t1_wr_gap", w_cyc[1] - w_cyc[0], 4);
        end
        check("t1_nstart", s_cyc.size(), 1);
        if (s_cyc.size() == 1 && w_cyc.size() == 2)
            check("t1_start_lat", s_cyc[0] - w_cyc[1], 1);
        check("t1_done", {31'd0, m_done}, 32'd1);
        check("t1_busy", {31'd0, m_busy}, 32'd0);
        check("t1_collide", collide, 0);

        // ---- partial final word ----
        pulse_reset("t2");
        stim[0]=8'hAA; stim[1]=8'hBB; stim[2]=8'hCC; stim[3]=8'hDD; stim[4]=8'hEE;
        run_stream(5, 1'b1, 1'b0);
        idle_cycles(5);
        check("t2_nwr", w_addr.size(), 2);
        if (w_addr.size() == 2) begin
            check("t2_a0", w_addr[0], 32'h0);
            check("t2_d0", w_data[0], 32'hDDCCBBAA);
            check("t2_a1", w_addr[1], 32'h4);
            check("t2_d1", w_data[1], 32'h000000EE);
        end
        check("t2_nstart", s_cyc.size(), 1);
        if (s_cyc.size() == 1 && w_cyc.size() == 2)
            check("t2_start_lat", s_cyc[0] - w_cyc[1], 1);
        check("t2_collide", collide, 0);

        // ---- overflow on a two-word memory ----
        sel = 1'b1;
        pulse_reset("t3");
        for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
        run_stream(9, 1'b0, 1'b0);
        idle_cycles(4);
        check("t3_nwr", w_addr.size(), 2);
        if (w_addr.size() == 2) begin
            check("t3_d0", w_data[0], 32'h04030201);
            check("t3_d1", w_data[1], 32'h08070605);
            check("t3_a1", w_addr[1], 32'h4);
        end
        @(negedge clk);
        check("t3_err", {31'd0, m_err}, 32'd1);
        check("t3_ready", {31'd0, m_ready}, 32'd0);
        check("t3_nstart", s_cyc.size(), 0);
        check("t3_done", {31'd0, m_done}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b0;

        // ---- reset mid-load ----
        pulse_reset("t4a");
        stim[0]=8'h55; stim[1]=8'h66; stim[2]=8'h77;
        run_stream(3, 1'b0, 1'b0);
        idle_cycles(2);
        check("t4_nwr_pre", w_addr.size(), 0);
        check("t4_busy_pre", {31'd0, m_busy}, 32'd1);
        pulse_reset("t4b");
        stim[0]=8'h01; stim[1]=8'h02; stim[2]=8'h03; stim[3]=8'h04;
        run_stream(4, 1'b1, 1'b0);
        idle_cycles(4);
        check("t4_nwr", w_addr.size(), 1);
        if (w_addr.size() == 1) begin
            check("t4_a0", w_addr[0], 32'h0);
            check("t4_d0", w_data[0], 32'h04030201);
        end
        check("t4_nstart", s_cyc.size(), 1);

        // ---- 32-byte stream, gap-free then gapped ----
        pulse_reset("t5a");
        for (int i = 0; i < 32; i++) stim[i] = 8'(i * 37 + 5);
        run_stream(32, 1'b1, 1'b0);
        idle_cycles(5);
        check("t5_nwr", w_addr.size(), 8);
        ref_data.delete();
        for (int w = 0; w < 8; w++) begin
            exp_w = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
            ref_data.push_back(exp_w);
            if (w < w_addr.size()) begin
                check($sformatf("t5_d%0d", w), w_data[w], exp_w);
                check($sformatf("t5_a%0d", w), w_addr[w], 32'(4 * w));
                if (w > 0) check($sformatf("t5_gap%0d", w), w_cyc[w] - w_cyc[w-1], 4);
            end
        end
        pulse_reset("t5b");
        run_stream(32, 1'b1, 1'b1);
        idle_cycles(5);
        check("t5g_nwr", w_addr.size(), 8);
        for (int w = 0; w < 8 && w < w_addr.size(); w++) begin
            check($sformatf("t5g_d%0d", w), w_data[w], ref_data[w]);
            check($sformatf("t5g_a%0d", w), w_addr[w], 32'(4 * w));
        end
        check("t5g_nstart", s_cyc.size(), 1);
        check("t5g_collide", collide, 0);

        // ---- bytes offered after DONE ----
        check("t6_done", {31'd0, m_done}, 32'd1);
        wr_snap = w_addr.size();
        st_snap = s_cyc.size();
        rdy_seen = 0;
        byte_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            byte_data = 8'(8'hF0 + i);
            last = i[0];
            @(negedge clk);
            if (m_ready) rdy_seen++;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0; last = 1'b0;
        idle_cycles(3);
        check("t6_ready", rdy_seen, 0);
        check("t6_nwr", w_addr.size(), wr_snap);
        check("t6_nstart", s_cyc.size(), st_snap);
        check("t6_done_hold", {31'd0, m_done}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256; instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0; byte address of the first written word.
REQ-003 SHALL have port clk_i, input, 1; single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset, asynchronous, active-high.
REQ-005 SHALL have port byte_valid_i, input, 1; source presents a program byte.
REQ-006 SHALL have port byte_data_i, input, 8; program byte.
REQ-007 SHALL have port last_i, input, 1; qualified by the handshake, marks the final program byte.
REQ-008 SHALL have port byte_ready_o, output, 1; loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en_o, output, 1; instruction-memory write strobe, one-cycle pulse.
REQ-010 SHALL have port wr_addr_o, output, 32; byte address of the word being written.
REQ-011 SHALL have port wr_data_o, output, 32; word being written.
REQ-012 SHALL have port start_o, output, 1; one-cycle pulse releasing the CPU after a successful load.
REQ-013 SHALL have port busy_o, output, 1; load in progress.
REQ-014 SHALL have port done_o, output, 1; load completed, sticky.
REQ-015 SHALL have port err_o, output, 1; overflow, sticky.

Function
REQ-016 SHALL implement states IDLE, LOAD, FIN, DONE, ERR.
REQ-017 A byte SHALL transfer on a rising edge with byte_valid_i=1 and byte_ready_o=1; byte_ready_o SHALL be 1 only in IDLE and LOAD and SHALL NOT depend on byte_valid_i.
REQ-018 IDLE SHALL move to LOAD on the first handshake; busy_o SHALL be 1 in LOAD and FIN.
REQ-019 Bytes SHALL assemble little-endian: byte k of a word (k=0..3) fills bits [8k+7:8k].
REQ-020 On the handshake completing a word (k=3), wr_en_o SHALL pulse in the next cycle, with wr_addr_o = BASE_ADDR + 4*word_index and wr_data_o = assembled word; word_index SHALL then increment.
REQ-021 wr_data_o/wr_addr_o SHALL be held in a dedicated register, so byte handshakes continue in the write cycle; sustained throughput SHALL be one byte per cycle.
REQ-022 A handshake with last_i=1 SHALL move to FIN; unfilled bytes of the partial word SHALL be zero, and wr_en_o SHALL pulse in the next cycle, also when k=3.
REQ-023 In FIN, start_o SHALL pulse exactly one cycle, in the cycle after the final wr_en_o; the state SHALL then be DONE.
REQ-024 DONE SHALL hold done_o=1 and byte_ready_o=0 and ignore all inputs until reset.
REQ-025 A handshake while word_index = DEPTH_WORDS SHALL discard the byte and move to ERR without a write; ERR SHALL hold err_o=1 and byte_ready_o=0, with start_o never asserted, until reset.
REQ-026 Handshake gaps (byte_valid_i=0) SHALL NOT change assembly state.
REQ-027 wr_en_o and start_o SHALL never be 1 in the same cycle.
REQ-028 word_index SHALL be wide enough to count to DEPTH_WORDS with no wrap-around.

Reset
REQ-029 rst_i=1 SHALL immediately force state IDLE and clear the assembly buffer, byte count and word_index.
REQ-030 rst_i=1 SHALL immediately force wr_en_o, wr_addr_o, wr_data_o, start_o, busy_o, done_o, err_o and byte_ready_o to 0.
REQ-031 Reset mid-load SHALL lose the partial word with no write, and the next load SHALL begin at BASE_ADDR.

Verification
REQ-032 Bytes 13 00 00 00 93 00 10 00 back-to-back, last on 8th -> write @0 32'h00000013, write @4 32'h00100093, start_o one cycle after the second write, then done_o=1.
REQ-033 Bytes AA BB CC DD EE, last on EE -> write @0 32'hDDCCBBAA, write @4 32'h000000EE, then start_o.
REQ-034 DEPTH_WORDS=2, nine bytes without last -> two writes, 9th byte -> err_o=1, byte_ready_o=0, no start_o.
REQ-035 rst_i pulsed after 3 bytes, then 4 bytes 01 02 03 04 with last -> no write before reset, outputs 0 during reset, then write @0 32'h04030201.
REQ-036 32-byte stream with random byte_valid_i gaps -> identical writes to the gap-free run; with no gaps, wr_en_o every 4th cycle.
REQ-037 Bytes after DONE -> byte_ready_o=0, no further wr_en_o or start_o.
